// File: rtl/morse_sequencer.sv
// Morse tone sequencer: walks up to five 2-bit symbols MSB-first and times
// short/long tones, silent word spaces and inter-symbol gaps for the codec.
module morse_sequencer #(
  parameter int DOT_TICKS  = 2,
  parameter int DASH_TICKS = 6,
  parameter int GAP_TICKS  = 2,
  parameter int CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_tick,
  input  logic [9:0] i_morse,
  output logic       o_audio_enable,
  output logic       o_short,
  output logic       o_long,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_sym_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TONE, S_SPACE, S_GAP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_TICKS - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [2:0]       MAX_SYM = 3'd5;

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_nsym, w_nsym_nxt;
  logic [2:0]       r_sym_idx, w_sym_idx_nxt;
  logic             r_sel_long, w_sel_long_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_nsym     <= '0;
      r_sym_idx  <= '0;
      r_sel_long <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_nsym     <= w_nsym_nxt;
      r_sym_idx  <= w_sym_idx_nxt;
      r_sel_long <= w_sel_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_cnt_nxt      = r_cnt;
    w_nsym_nxt     = r_nsym;
    w_sym_idx_nxt  = r_sym_idx;
    w_sel_long_nxt = r_sel_long;
    // Abort freezes the datapath and only forces the state home.
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_shreg_nxt = i_morse;
            w_nsym_nxt  = '0;
            w_state_nxt = S_FETCH;
          end
        end
        S_FETCH: begin
          w_shreg_nxt   = {r_shreg[7:0], 2'b00};
          w_sym_idx_nxt = r_nsym;
          w_nsym_nxt    = r_nsym + 3'd1;
          case (r_shreg[9:8])
            2'b01: begin
              w_state_nxt    = S_TONE;
              w_cnt_nxt      = DOT_LD;
              w_sel_long_nxt = 1'b0;
            end
            2'b10: begin
              w_state_nxt    = S_TONE;
              w_cnt_nxt      = DASH_LD;
              w_sel_long_nxt = 1'b1;
            end
            2'b11: begin
              w_state_nxt = S_SPACE;
              w_cnt_nxt   = DASH_LD;
            end
            default: w_state_nxt = S_DONE;
          endcase
        end
        S_TONE, S_SPACE: begin
          if (i_tick) begin
            if (w_cnt_zero) begin
              w_state_nxt = S_GAP;
              w_cnt_nxt   = GAP_LD;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (i_tick) begin
            if (w_cnt_zero)
              w_state_nxt = (r_nsym == MAX_SYM) ? S_DONE : S_FETCH;
            else
              w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  assign o_audio_enable = (r_state == S_TONE);
  assign o_short        = (r_state == S_TONE) && !r_sel_long;
  assign o_long         = (r_state == S_TONE) &&  r_sel_long;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_sym_idx      = r_sym_idx;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: directed table, hand-written corner sequences and
// a random run against a phase-queue reference model.
module tb_morse_sequencer;

  localparam int DOT = 2, DASH = 6, GAP = 2;
  localparam int K_FETCH = 0, K_SHORT = 1, K_LONG = 2, K_SPACE = 3, K_GAP = 4, K_DONE = 5;

  logic       clk, rst_n, start, abort, tick;
  logic [9:0] morse;
  logic       audio, shrt, lng, busy, done;
  logic [2:0] sym_idx;

  morse_sequencer #(.DOT_TICKS(DOT), .DASH_TICKS(DASH), .GAP_TICKS(GAP), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort), .i_tick(tick),
    .i_morse(morse), .o_audio_enable(audio), .o_short(shrt), .o_long(lng),
    .o_busy(busy), .o_done(done), .o_sym_idx(sym_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int kind; int rem; int idx; } ph_t;
  typedef struct { logic [9:0] w; int done_c; int n_audio; int n_short; int last_idx; } vec_t;

  ph_t q[$];
  int  m_idx;
  int  nchk, npass;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic ph_t mk(input int k, input int r, input int i);
    ph_t p;
    p.kind = k; p.rem = r; p.idx = i;
    return p;
  endfunction

  // Expand a word into the ordered list of phases it will play.
  task automatic build(input logic [9:0] w);
    logic [1:0] s;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      s = w[9-2*i -: 2];
      q.push_back(mk(K_FETCH, 0, i));
      case (s)
        2'b00: begin q.push_back(mk(K_DONE, 0, 0)); return; end
        2'b01: q.push_back(mk(K_SHORT, DOT, 0));
        2'b10: q.push_back(mk(K_LONG, DASH, 0));
        default: q.push_back(mk(K_SPACE, DASH, 0));
      endcase
      q.push_back(mk(K_GAP, GAP, 0));
    end
    q.push_back(mk(K_DONE, 0, 0));
  endtask

  task automatic model_edge(input logic st, input logic ab, input logic tk, input logic [9:0] w);
    ph_t h;
    if (ab) q.delete();
    else if (q.size() == 0) begin
      if (st) build(w);
    end else begin
      h = q[0];
      if (h.kind == K_FETCH) begin m_idx = h.idx; void'(q.pop_front()); end
      else if (h.kind == K_DONE) void'(q.pop_front());
      else if (tk) begin
        if (h.rem == 1) void'(q.pop_front());
        else begin h.rem = h.rem - 1; q[0] = h; end
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    int k;
    if (q.size() == 0) return {5'b0, 3'(m_idx)};
    k = q[0].kind;
    return {(k == K_SHORT || k == K_LONG), (k == K_SHORT), (k == K_LONG), 1'b1,
            (k == K_DONE), 3'(m_idx)};
  endfunction

  task automatic check_outs(input string name);
    chk(name, int'({audio, shrt, lng, busy, done, sym_idx}), int'(model_out()));
  endtask

  task automatic cyc(input logic st, input logic ab, input logic tk, input logic [9:0] w);
    start = st; abort = ab; tick = tk; morse = w;
    @(posedge clk);
    model_edge(st, ab, tk, w);
    #1;
    check_outs("model");
  endtask

  task automatic run_to_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 200) begin cyc(0, 0, 1, 10'($urandom)); k++; end
    chk(name, int'(busy), 0);
  endtask

  task automatic rst_mid(input logic [9:0] w, input int ncyc, input int exp_audio);
    cyc(1, 0, 1, w);
    for (int k = 1; k < ncyc; k++) cyc(0, 0, 1, w);
    chk("rst_pre_audio", int'(audio), exp_audio);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", int'({audio, shrt, lng, busy, done, sym_idx}), 0);
    q.delete(); m_idx = 0;
    #2 rst_n = 1'b1;
    cyc(0, 0, 1, w);
    chk("rst_idle", int'(busy), 0);
  endtask

  vec_t tv[6];

  initial begin
    int c, done_c, na, ns, cnt_s, edges;
    logic prev;
    nchk = 0; npass = 0; m_idx = 0;
    tv[0] = '{10'b01_10_00_00_00, 16, 8, 2, 2};
    tv[1] = '{10'b01_01_01_01_01, 26, 10, 10, 4};
    tv[2] = '{10'b11_01_00_00_00, 16, 2, 2, 2};
    tv[3] = '{10'b00_01_10_11_01, 2, 0, 0, 0};
    tv[4] = '{10'b10_11_00_00_00, 20, 6, 0, 2};
    tv[5] = '{10'b11_11_11_11_11, 46, 0, 0, 4};

    rst_n = 1'b0; start = 0; abort = 0; tick = 0; morse = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", int'({audio, shrt, lng, busy, done, sym_idx}), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 0, 1, '0);

    // Directed table, tick = 1; morse is scrambled after latching.
    foreach (tv[t]) begin
      cyc(1, 0, 1, tv[t].w);
      c = 1; done_c = -1; na = 0; ns = 0;
      while (busy && c < 80) begin
        if (audio) na++;
        if (shrt) ns++;
        if (done) done_c = c;
        cyc(0, 0, 1, 10'($urandom));
        c++;
      end
      chk($sformatf("tv%0d_done_cycle", t), done_c, tv[t].done_c);
      chk($sformatf("tv%0d_audio_cycles", t), na, tv[t].n_audio);
      chk($sformatf("tv%0d_short_cycles", t), ns, tv[t].n_short);
      chk($sformatf("tv%0d_sym_idx", t), int'(sym_idx), tv[t].last_idx);
      chk($sformatf("tv%0d_idle", t), int'(busy), 0);
    end

    // Start re-pulsed while busy with another word must not disturb the run.
    cyc(1, 0, 1, 10'b01_10_00_00_00);
    c = 1; done_c = -1;
    while (busy && c < 80) begin
      if (done) done_c = c;
      cyc(c < 10, 0, 1, 10'b11_11_11_11_11);
      c++;
    end
    chk("restart_ignored_done", done_c, 16);

    // Tick once every 4 cycles: short tone stretches and stays stable.
    cyc(1, 0, 1, 10'b01_00_00_00_00);
    cnt_s = 0; edges = 0; prev = 1'b0; c = 0;
    while (busy && c < 100) begin
      if (shrt) cnt_s++;
      if (shrt != prev) edges++;
      prev = shrt;
      cyc(0, 0, (c % 4) == 0, '0);
      c++;
    end
    chk("tick4_len_in_range", int'(cnt_s >= 5 && cnt_s <= 11), 1);
    chk("tick4_short_stable", edges, 2);

    // Abort in the 3rd cycle of a long tone, then an immediate restart.
    cyc(1, 0, 1, 10'b10_00_00_00_00);
    cyc(0, 0, 1, '0); cyc(0, 0, 1, '0); cyc(0, 0, 1, '0);
    chk("abort_pre_long", int'(lng), 1);
    cyc(0, 1, 1, '0);
    chk("abort_outs", int'({audio, shrt, lng, busy, done}), 0);
    cyc(1, 0, 1, 10'b01_00_00_00_00);
    chk("abort_restart_busy", int'(busy), 1);
    run_to_idle("abort_restart_finish");

    // Start and abort together in IDLE: abort wins.
    cyc(1, 1, 1, 10'b01_00_00_00_00);
    chk("start_abort_idle", int'(busy), 0);

    rst_mid(10'b01_00_00_00_00, 4, 0);   // mid-GAP
    rst_mid(10'b10_00_00_00_00, 3, 1);   // mid-tone

    // Random run: random words, starts, rare aborts, tick both solid and sparse.
    for (int k = 0; k < 5000; k++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
          (k < 2500) ? 1'b1 : ($urandom_range(0, 2) == 0), 10'($urandom));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
